// File: rtl/dff_share_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
package dff_share_pkg;

  // ARB: free arbitration each edge; OWN: last winner holds a lock.
  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } state_e;

  // Index to one-hot vector; callers size-cast to their vector width.
  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction

  // Round-robin pointer advance with wrap from n-1 back to 0.
  function automatic int wrap_inc(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any_req,
  output logic [IDW-1:0]     win_idx
);

  // Scan ptr, ptr+1, ... with wrap; the first hit wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        win_idx = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// One WIDTH-bit register shared by NUM_REQ writers through a round-robin
// arbiter, with bounded ownership locking.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 3,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] D,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         Q,
  output logic                     q_valid,
  output logic [IDW-1:0]           owner
);

  localparam int HCW = $clog2(MAX_HOLD + 1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;

  logic               any_req;
  logic [IDW-1:0]     win_idx;
  logic               keep;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any_req (any_req),
    .win_idx (win_idx)
  );

  // Locked owner keeps the register while it still requests, locks, and has budget.
  assign keep = (state_q == OWN) && req[owner_q] && lock[owner_q] &&
                (int'(hold_q) < MAX_HOLD);

  // Next state: continue a hold, otherwise a full arbitration on the same edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    q_d     = q_q;
    owner_d = owner_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    if (keep) begin
      q_d    = D[int'(owner_q)*WIDTH +: WIDTH];
      gnt_d  = NUM_REQ'(onehot(int'(owner_q)));
      vld_d  = 1'b1;
      hold_d = hold_q + HCW'(1);
    end else if (any_req) begin
      q_d     = D[int'(win_idx)*WIDTH +: WIDTH];
      gnt_d   = NUM_REQ'(onehot(int'(win_idx)));
      vld_d   = 1'b1;
      owner_d = win_idx;
      ptr_d   = IDW'(wrap_inc(int'(win_idx), NUM_REQ));
      hold_d  = HCW'(1);
      state_d = (lock[win_idx] && (MAX_HOLD > 1)) ? OWN : ARB;
    end else begin
      state_d = ARB;
    end
  end

  // State, pointer, hold counter and the shared storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      hold_q  <= '0;
      q_q     <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt     = gnt_q;
  assign Q       = q_q;
  assign q_valid = vld_q;
  assign owner   = owner_q;

endmodule
